alarm_route_1x4: RTL and testbench

ALARM_ROUTE_1X4 -- requirements
Module: alarm_route_1x4

---
 rtl/alarm_route_pkg.sv | 15 +
 rtl/alarm_route_slot.sv | 40 ++++
 rtl/alarm_route_1x4.sv | 59 +++++
 tb/tb_alarm_route_1x4.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alarm_route_pkg.sv
// alarm_route_pkg: shared constants for the 1x4 alarm router (channel count, select codes, counter width, slot states)
package alarm_route_pkg;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 8;
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;
  localparam logic EMPTY = 1'b0;
  localparam logic FULL = 1'b1;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/alarm_route_slot.sv
// alarm_route_slot: one-entry buffer; ports clk, reset, load/load_data in, drain_ready in, valid/ready/data out, cnt out when ALARM_ROUTE_STATS_EN
module alarm_route_slot
  import alarm_route_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         drain_ready,
  output logic         valid,
  output logic         ready,
  output logic [N-1:0] data
`ifdef ALARM_ROUTE_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  logic state;
  logic drain;
  assign valid = state == FULL;
  assign drain = valid && drain_ready;
  assign ready = !valid || drain_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      data <= '0;
    end else begin
      state <= load ? FULL : drain ? EMPTY : state;
      if (load) data <= load_data;
    end
  end
`ifdef ALARM_ROUTE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (drain) cnt <= sat_inc(cnt);
  end
`endif
endmodule

// File: rtl/alarm_route_1x4.sv
// alarm_route_1x4: routes one alarm stream to four one-entry channels by in_sel; ports clk, reset, in_valid/in_ready/in_data/in_sel, out_valid[3:0], out_ready[3:0], out_data0..3, cnt0..3 when ALARM_ROUTE_STATS_EN
module alarm_route_1x4
  import alarm_route_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3
`ifdef ALARM_ROUTE_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);
  logic [NUM_CH-1:0] slot_ready;
  logic [N-1:0] slot_data [NUM_CH];
`ifdef ALARM_ROUTE_STATS_EN
  cnt_t slot_cnt [NUM_CH];
`endif
  assign in_ready = slot_ready[in_sel];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    alarm_route_slot #(.N(N)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (in_valid && in_ready && in_sel == 2'(i)),
      .load_data  (in_data),
      .drain_ready(out_ready[i]),
      .valid      (out_valid[i]),
      .ready      (slot_ready[i]),
      .data       (slot_data[i])
`ifdef ALARM_ROUTE_STATS_EN
      ,
      .cnt        (slot_cnt[i])
`endif
    );
  end
  assign out_data0 = slot_data[CH0];
  assign out_data1 = slot_data[CH1];
  assign out_data2 = slot_data[CH2];
  assign out_data3 = slot_data[CH3];
`ifdef ALARM_ROUTE_STATS_EN
  assign cnt0 = slot_cnt[CH0];
  assign cnt1 = slot_cnt[CH1];
  assign cnt2 = slot_cnt[CH2];
  assign cnt3 = slot_cnt[CH3];
`endif
endmodule

// File: tb/tb_alarm_route_1x4.sv
// tb_alarm_route_1x4: scoreboard bench for alarm_route_1x4 with per-channel expected-code queues
module tb_alarm_route_1x4;
  localparam int N = 6;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic [1:0] in_sel = 0;
  logic [N-1:0] in_data = 0;
  logic [3:0] out_ready = 0;
  logic in_ready;
  logic [3:0] out_valid;
  logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [N-1:0] od [4];
`ifdef ALARM_ROUTE_STATS_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [7:0] oc [4];
  always_comb begin
    oc[0] = cnt0;
    oc[1] = cnt1;
    oc[2] = cnt2;
    oc[3] = cnt3;
  end
`endif
  always_comb begin
    od[0] = out_data0;
    od[1] = out_data1;
    od[2] = out_data2;
    od[3] = out_data3;
  end

  alarm_route_1x4 #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef ALARM_ROUTE_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    int c;
  } ent_t;
  ent_t q [4][$];
  logic [N-1:0] last [4];
  int cnt_m [4];
  int cyc = 0;
  int checks = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // an entry pushed in the current cycle is not yet in the DUT
  function automatic bit held(input int k);
    return q[k].size() > 0 && q[k][0].c < cyc;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", int'(in_ready), int'(!held(int'(in_sel)) || out_ready[in_sel]));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid%0d", k), int'(out_valid[k]), int'(held(k)));
        check($sformatf("out_data%0d", k), int'(od[k]), int'(held(k) ? q[k][0].d : last[k]));
`ifdef ALARM_ROUTE_STATS_EN
        check($sformatf("cnt%0d", k), int'(oc[k]), cnt_m[k]);
`endif
        if (held(k) && out_ready[k]) begin
          last[k] = q[k][0].d;
          q[k].delete(0);
          cnt_m[k] = cnt_m[k] < 255 ? cnt_m[k] + 1 : 255;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] sel, input logic [N-1:0] d, input logic [3:0] ordy);
    in_valid = v;
    in_sel = sel;
    in_data = d;
    out_ready = ordy;
    if (v && !reset && (q[sel].size() == 0 || ordy[sel])) q[sel].push_back(ent_t'{d, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 1'($urandom);
    out_ready = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k] = '0;
      cnt_m[k] = 0;
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      last[k] = '0;
      cnt_m[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_ready", int'(in_ready), 1);
    step(1, 2'b10, 6'h2A, 4'b0000);
    check("t28_valid", int'(out_valid), 4'b0100);
    check("t28_data2", int'(out_data2), 6'h2A);
    in_valid = 0;
    in_sel = 2'b00;
    #1;
    check("t28_ready_ch0", int'(in_ready), 1);
    step(0, 0, 0, 4'b0100);
    step(1, 2'b01, 6'h11, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'b01, 6'($urandom), 4'b0000);
      check("t29_ready_blocked", int'(in_ready), 0);
      check("t29_data1_hold", int'(out_data1), 6'h11);
    end
    out_ready = 4'b0010;
    #1;
    check("t29_ready_release", int'(in_ready), 1);
    step(1, 2'b01, 6'h12, 4'b0010);
    check("t29_new_data1", int'(out_data1), 6'h12);
    check("t29_valid1", int'(out_valid[1]), 1);
    step(0, 0, 0, 4'b1111);
    do_reset();
    step(1, 2'b11, 6'h05, 4'b0000);
    step(1, 2'b11, 6'h06, 4'b1000);
    check("t30_valid3", int'(out_valid[3]), 1);
    check("t30_data3", int'(out_data3), 6'h06);
`ifdef ALARM_ROUTE_STATS_EN
    check("t30_cnt3", int'(cnt3), 1);
`endif
    step(0, 0, 0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      step(1, 2'(k), 6'(k + 1), 4'b1111);
      check($sformatf("t31_data%0d", k), int'(od[k]), k + 1);
      check($sformatf("t31_valid%0d", k), int'(out_valid[k]), 1);
    end
    step(0, 0, 0, 4'b1111);
    check("t31_drained", int'(out_valid), 0);
    for (int k = 0; k < 4; k++) step(1, 2'(k), 6'($urandom), 4'b0000);
    check("t32_full", int'(out_valid), 4'b1111);
    do_reset();
    check("t32_valid", int'(out_valid), 0);
    check("t32_ready", int'(in_ready), 1);
    for (int k = 0; k < 4; k++) check($sformatf("t32_data%0d", k), int'(od[k]), 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step(1'($urandom), 2'($urandom_range(3)), 6'($urandom), 4'($urandom));
    end
`ifdef ALARM_ROUTE_STATS_EN
    do_reset();
    for (int i = 0; i < 301; i++) step(1, 2'b10, 6'(i), 4'b0100);
    check("t33_cnt2", int'(cnt2), 255);
    check("t33_cnt0", int'(cnt0), 0);
    check("t33_cnt1", int'(cnt1), 0);
    check("t33_cnt3", int'(cnt3), 0);
`endif
    step(0, 0, 0, 4'b1111);
    step(0, 0, 0, 4'b1111);
    for (int k = 0; k < 4; k++) check($sformatf("leftover%0d", k), q[k].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
